angle_unfold: RTL and testbench

- Sits directly after the atan polynomial stage. It is the consumer end of the octant-folding path.
- Takes the first-octant angle atan(min/max) and the 3-bit case_flag produced by the folding/division stage, and reconstructs the full-circle signed angle.
- Also emits the wrapped phase difference between consecutive valid samples, for downstream frequency/phase tracking.

---
 rtl/angle_unfold.sv | 110 +++++++++++
 tb/tb_angle_unfold.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/angle_unfold.sv
// Octant unfolding after the atan polynomial: rebuilds the full-circle binary
// angle from the first-octant atan and case code, and emits wrapped phase steps.
module angle_unfold #(
  parameter int ATAN_W = 14,
  parameter int ANG_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              val_i,
  input  logic [ATAN_W-1:0] atan_i,
  input  logic [2:0]        case_flag_i,
  input  logic              clr_i,
  output logic [ANG_W-1:0]  angle_o,
  output logic              val_o,
  output logic [ANG_W-1:0]  dphi_o,
  output logic              dphi_val_o
);

  localparam logic [ATAN_W-1:0] Q4   = {1'b1, {(ATAN_W-1){1'b0}}};
  localparam logic [ANG_W-1:0]  QTR  = {2'b01, {(ANG_W-2){1'b0}}};
  localparam logic [ANG_W-1:0]  HALF = {2'b10, {(ANG_W-2){1'b0}}};
  localparam logic [ANG_W-1:0]  ZERO = {ANG_W{1'b0}};

  logic              val1_r;
  logic [2:0]        case1_r;
  logic [ATAN_W-1:0] t1_r;
  logic [ATAN_W-1:0] t_clamp_s;
  logic [ANG_W-1:0]  t_ext_s;
  logic [ANG_W-1:0]  angle_s;
  logic [ANG_W-1:0]  prev_angle_r;
  logic              have_prev_r;

  // Clamp polynomial overshoot beyond pi/4
  always_comb begin
    t_clamp_s = atan_i;
    if (atan_i > Q4) begin
      t_clamp_s = Q4;
    end else begin
      t_clamp_s = atan_i;
    end
  end

  // Stage 1 register: clamped angle, octant code, valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val1_r  <= 1'b0;
      case1_r <= 3'd0;
      t1_r    <= {ATAN_W{1'b0}};
    end else begin
      val1_r  <= val_i;
      case1_r <= case_flag_i;
      t1_r    <= t_clamp_s;
    end
  end

  // Octant reconstruction, all arithmetic wraps modulo 2*pi
  always_comb begin
    t_ext_s = ANG_W'(t1_r);
    angle_s = t_ext_s;
    case (case1_r)
      3'd0:    angle_s = t_ext_s - HALF;
      3'd1:    angle_s = t_ext_s;
      3'd2:    angle_s = HALF - t_ext_s;
      3'd3:    angle_s = ZERO - t_ext_s;
      3'd4:    angle_s = ZERO - QTR - t_ext_s;
      3'd5:    angle_s = QTR - t_ext_s;
      3'd6:    angle_s = QTR + t_ext_s;
      3'd7:    angle_s = t_ext_s - QTR;
      default: angle_s = t_ext_s;
    endcase
  end

  // Stage 2 register: angle holds while no sample is valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_o   <= 1'b0;
      angle_o <= {ANG_W{1'b0}};
    end else begin
      val_o <= val1_r;
      if (val1_r) begin
        angle_o <= angle_s;
      end
    end
  end

  // Stage 3: phase difference; clr_i overrides the history flag even on a valid sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dphi_o       <= {ANG_W{1'b0}};
      dphi_val_o   <= 1'b0;
      prev_angle_r <= {ANG_W{1'b0}};
      have_prev_r  <= 1'b0;
    end else begin
      dphi_val_o <= 1'b0;
      if (val_o) begin
        prev_angle_r <= angle_o;
      end
      if (clr_i) begin
        have_prev_r <= 1'b0;
      end else if (val_o) begin
        have_prev_r <= 1'b1;
        if (have_prev_r) begin
          dphi_o     <= angle_o - prev_angle_r;
          dphi_val_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_angle_unfold.sv
// Scoreboard bench for angle_unfold: a slot plan drives the DUT, a reference
// model pushes expected records, and a negedge monitor pops and compares.
module tb_angle_unfold;

  localparam int ATAN_W = 14;
  localparam int ANG_W  = 16;
  localparam int MAXS   = 512;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              val_i;
  logic [ATAN_W-1:0] atan_i;
  logic [2:0]        case_flag_i;
  logic              clr_i;
  logic [ANG_W-1:0]  angle_o;
  logic              val_o;
  logic [ANG_W-1:0]  dphi_o;
  logic              dphi_val_o;

  always #5 clk = ~clk;

  angle_unfold #(.ATAN_W(ATAN_W), .ANG_W(ANG_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .val_i       (val_i),
    .atan_i      (atan_i),
    .case_flag_i (case_flag_i),
    .clr_i       (clr_i),
    .angle_o     (angle_o),
    .val_o       (val_o),
    .dphi_o      (dphi_o),
    .dphi_val_o  (dphi_val_o)
  );

  typedef struct {
    logic [15:0] ang;
    int          o;
    bit          has_d;
    logic [15:0] d;
  } rec_t;

  rec_t sb[$];
  rec_t mon_r;
  rec_t drv_r;

  int n_checks = 0;
  int n_fail   = 0;
  int slot     = -100;

  int p_val[MAXS];
  int p_atan[MAXS];
  int p_case[MAXS];
  int p_clr[MAXS];
  int p_rst[MAXS];
  int p_exp[MAXS];
  int ns = 0;

  task automatic add(input int v, input int a, input int c, input int cl, input int rs, input int ex);
    p_val[ns]  = v;
    p_atan[ns] = a;
    p_case[ns] = c;
    p_clr[ns]  = cl;
    p_rst[ns]  = rs;
    p_exp[ns]  = ex;
    ns++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) add(0, 0, 0, 0, 0, -1);
  endtask

  // Full-circle angle in units of 2*pi/65536, from octant rules with plain integers
  function automatic logic [15:0] ref_angle(input int a, input int c);
    int t;
    int r;
    t = (a > 8192) ? 8192 : a;
    case (c)
      0: r = -32768 + t;
      1: r = t;
      2: r = 32768 - t;
      3: r = -t;
      4: r = -16384 - t;
      5: r = 16384 - t;
      6: r = 16384 + t;
      7: r = -16384 + t;
      default: r = 0;
    endcase
    r = ((r % 65536) + 65536) % 65536;
    return 16'(r);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at slot %0d: got 0x%04h required 0x%04h", name, slot, act, exp);
    end
  endtask

  bit          pend = 1'b0;
  bit          pend_has = 1'b0;
  logic [15:0] pend_d = 16'h0000;
  logic [15:0] last_ang = 16'h0000;

  // Monitor: pops one record per val_o and checks the dphi one cycle later
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_angle", angle_o, 16'h0000);
      check("rst_val", {15'd0, val_o}, 16'h0000);
      check("rst_dphi", dphi_o, 16'h0000);
      check("rst_dphi_val", {15'd0, dphi_val_o}, 16'h0000);
      pend = 1'b0;
      last_ang = 16'h0000;
    end else begin
      if (pend) begin
        check("dphi_val", {15'd0, dphi_val_o}, {15'd0, pend_has});
        if (pend_has) check("dphi", dphi_o, pend_d);
        pend = 1'b0;
      end else begin
        check("dphi_val_idle", {15'd0, dphi_val_o}, 16'h0000);
      end
      if (val_o) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_val_o at slot %0d: got angle 0x%04h required no sample", slot, angle_o);
        end else begin
          mon_r = sb.pop_front();
          check("angle", angle_o, mon_r.ang);
          n_checks++;
          if (slot != mon_r.o) begin
            n_fail++;
            $display("FAIL latency: val_o at slot %0d required slot %0d", slot, mon_r.o);
          end
          pend     = 1'b1;
          pend_has = mon_r.has_d;
          pend_d   = mon_r.d;
          last_ang = mon_r.ang;
        end
      end else begin
        check("angle_hold", angle_o, last_ang);
      end
    end
  end

  int          hp;
  logic [15:0] prev_m;
  int          last_o;
  int          o;

  initial begin
    val_i = 1'b0;
    clr_i = 1'b0;
    atan_i = '0;
    case_flag_i = 3'd0;
    hp = 0;
    prev_m = 16'h0000;
    last_o = -1;

    // Plan: octant sweep, clamp, dphi wrap, gaps, clr, reset, then random traffic
    idle(2);
    add(1, 1000, 0, 0, 0, 32'h83E8);
    add(1, 1000, 1, 0, 0, 32'h03E8);
    add(1, 1000, 2, 0, 0, 32'h7C18);
    add(1, 1000, 3, 0, 0, 32'hFC18);
    add(1, 1000, 4, 0, 0, 32'hBC18);
    add(1, 1000, 5, 0, 0, 32'h3C18);
    add(1, 1000, 6, 0, 0, 32'h43E8);
    add(1, 1000, 7, 0, 0, 32'hC3E8);
    idle(2);
    add(1, 9000, 1, 0, 0, 8192);
    add(1, 8192, 5, 0, 0, 8192);
    add(1, 0, 0, 0, 0, 32'h8000);
    idle(3);
    add(0, 0, 0, 1, 0, -1);
    add(1, 1000, 2, 0, 0, 31768);
    add(1, 1000, 0, 0, 0, 32'h83E8);
    idle(3);
    add(1, 500, 1, 0, 0, -1);
    idle(2);
    add(1, 200, 6, 0, 0, -1);
    idle(3);
    add(1, 3000, 3, 0, 0, -1);
    add(1, 4000, 4, 0, 0, -1);
    add(1, 5000, 7, 1, 0, -1);
    idle(3);
    add(1, 1234, 5, 0, 0, -1);
    add(1, 2345, 6, 0, 0, -1);
    add(0, 0, 0, 0, 1, -1);
    add(1, 777, 2, 0, 0, -1);
    idle(3);
    for (int i = 0; i < 300; i++) begin
      int v, a, c, cl;
      v  = ($urandom_range(0, 9) < 7) ? 1 : 0;
      a  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 8192));
      c  = int'($urandom_range(0, 7));
      cl = ($urandom_range(0, 19) == 0) ? 1 : 0;
      add(v, a, c, cl, 0, -1);
    end
    idle(6);

    repeat (3) @(posedge clk);
    for (int s = 0; s < ns; s++) begin
      @(posedge clk);
      #1;
      slot        = s;
      rst_n       = (p_rst[s] != 0) ? 1'b0 : 1'b1;
      val_i       = (p_val[s] != 0);
      atan_i      = 14'(p_atan[s]);
      case_flag_i = 3'(p_case[s]);
      clr_i       = (p_clr[s] != 0);

      if (p_rst[s] != 0) begin
        hp = 0;
        last_o = s;
      end
      // Samples caught by the reset window never reach the output
      if (p_val[s] != 0 && p_rst[s] == 0 && p_rst[s+1] == 0 && p_rst[s+2] == 0) begin
        o = s + 2;
        drv_r.ang = (p_exp[s] >= 0) ? 16'(p_exp[s]) : ref_angle(p_atan[s], p_case[s]);
        drv_r.o = o;
        drv_r.d = 16'h0000;
        for (int j = last_o + 1; j < o; j++) begin
          if (p_clr[j] != 0) hp = 0;
        end
        if (p_clr[o] != 0) begin
          drv_r.has_d = 1'b0;
          hp = 0;
        end else begin
          drv_r.has_d = (hp != 0);
          drv_r.d = drv_r.ang - prev_m;
          hp = 1;
        end
        prev_m = drv_r.ang;
        last_o = o;
        sb.push_back(drv_r);
      end
    end

    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL missing_samples: %0d outstanding, required 0", sb.size());
    end
    n_checks++;
    if (pend) begin
      n_fail++;
      $display("FAIL missing_dphi_check: pending 1, required 0");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
